// File: rtl/inst_fetch_pkg.sv
// Shared fetch-stage types and constants: word width, the buffered {pc, inst}
// entry layout, and small PC helpers.
package inst_fetch_pkg;

    localparam int PORT_WORD_WIDTH = 32;

    typedef logic [PORT_WORD_WIDTH-1:0] RegBus;

    localparam RegBus ZeroWord         = '0;
    localparam logic  Enable           = 1'b1;
    localparam logic  Disable          = 1'b0;
    localparam RegBus RESET_PC_DEFAULT = 32'h0000_0000;

    typedef struct packed {
        RegBus pc;
        RegBus inst;
    } fetch_entry_t;

    function automatic RegBus pc_next(input RegBus pc);
        return pc + 32'd4;
    endfunction

    function automatic RegBus word_index(input RegBus pc);
        return {2'b00, pc[31:2]};
    endfunction

endpackage

// File: rtl/inst_fetch_fifo.sv
// Fetch buffer: synchronous FIFO of {pc, inst} entries with flush priority.
// Latency: a push is visible at the head the next cycle.
// Backpressure: push is dropped when full without a pop; the caller never lets that happen.
module fetch_fifo
    import inst_fetch_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  fetch_entry_t push_dat,
    input  logic         pop,
    input  logic         flush,
    output fetch_entry_t head,
    output logic [CW-1:0] count
);

    fetch_entry_t  mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic          do_push;
    logic          do_pop;

    assign do_pop  = pop & (count != '0);
    assign do_push = push & ((count != CW'(DEPTH)) | do_pop);
    assign head    = mem[rd_ptr];

    // Storage is reset so the head reads as zero straight out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '{pc: ZeroWord, inst: ZeroWord};
            end
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_dat;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch: owns the PC, issues ROM word reads, buffers {pc, inst} for decode.
// Latency: 2 cycles from request to id_valid_o; one instruction per cycle in steady state.
// Backpressure: requests stop once buffered + outstanding entries would exceed FIFO_DEPTH.
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter RegBus RESET_PC   = RESET_PC_DEFAULT,
    parameter int    FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] rom_addr_o,
    output logic        rom_rd_valid_o,
    input  logic        rom_rd_ready_i,
    input  logic [31:0] rom_inst_i,
    input  logic        rom_inst_valid_i,
    output logic [31:0] id_inst_o,
    output logic [31:0] id_pc_o,
    output logic        id_valid_o,
    input  logic        id_ready_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);

    RegBus         pc_q;
    RegBus         out_pc_q;
    logic          out_q;
    logic          drop_q;
    logic          acc;
    logic          cap;
    logic          pop;
    logic          push;
    logic [CW-1:0] count;
    logic [3:0]    occ;
    fetch_entry_t  push_dat;
    fetch_entry_t  head;

    assign cap = out_q & rom_inst_valid_i;
    assign pop = id_valid_o & id_ready_i;

    // Occupancy after this cycle if the outstanding response lands; pop implies count >= 1.
    assign occ = 4'(count) + 4'(out_q) - 4'(pop);

    assign rom_rd_valid_o = ~rst & ~redirect_i & (~out_q | rom_inst_valid_i)
                          & (occ < 4'(FIFO_DEPTH));
    assign acc            = rom_rd_valid_o & rom_rd_ready_i;
    assign rom_addr_o     = word_index(pc_q);

    assign push     = cap & ~drop_q & ~redirect_i;
    assign push_dat = '{pc: out_pc_q, inst: rom_inst_i};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q     <= RESET_PC;
            out_pc_q <= ZeroWord;
            out_q    <= Disable;
            drop_q   <= Disable;
        end else if (redirect_i) begin
            // A response still in flight belongs to the old path and must be discarded.
            pc_q   <= {redirect_pc_i[31:2], 2'b00};
            drop_q <= out_q & ~cap;
            out_q  <= out_q & ~cap;
        end else begin
            if (acc) begin
                out_pc_q <= pc_q;
                pc_q     <= pc_next(pc_q);
                out_q    <= Enable;
            end else if (cap) begin
                out_q    <= Disable;
            end
            if (cap & drop_q) begin
                drop_q <= Disable;
            end
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .push_dat (push_dat),
        .pop      (pop),
        .flush    (redirect_i),
        .head     (head),
        .count    (count)
    );

    assign id_valid_o = (count != '0);
    assign id_inst_o  = head.inst;
    assign id_pc_o    = head.pc;

endmodule

// File: doc/inst_fetch.md
# inst_fetch

Instruction-fetch initiator: owns the program counter, drives word-address read requests into the instruction ROM, and collects the returned instruction words. Fetched `{pc, inst}` pairs are buffered in a small FIFO and presented to decode with a valid/ready handshake. A one-cycle redirect from execute reloads the PC and squashes every in-flight and buffered fetch. Sits between the ROM and the decode stage.

## Interface
- `RESET_PC`, default 32'h0000_0000: byte PC loaded on reset; bits[1:0] must be 0.
- `FIFO_DEPTH`, default 2: fetch buffer entries; legal values are 2 and 4.
- `clk`  in  1  system clock, all state on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `rom_addr_o`  out  32  ROM word index, equal to `{2'b00, pc_q[31:2]}`.
- `rom_rd_valid_o`  out  1  read request.
- `rom_rd_ready_i`  in  1  ROM accepts a request.
- `rom_inst_i`  in  32  ROM instruction data.
- `rom_inst_valid_i`  in  1  ROM data valid.
- `id_inst_o`  out  32  instruction to decode (FIFO head).
- `id_pc_o`  out  32  byte PC of `id_inst_o`.
- `id_valid_o`  out  1  head valid.
- `id_ready_i`  in  1  decode consumes head.
- `redirect_i`  in  1  one-cycle PC redirect / flush.
- `redirect_pc_i`  in  32  redirect target (byte address); bits[1:0] are forced to 0.

## Operation
- State:
  - `pc_q`: next PC to request.
  - `out_q`: 1 outstanding request.
  - `out_pc_q`: PC of the outstanding request.
  - `drop_q`: outstanding response is stale.
  - FIFO, with `count`.
- Accept: `acc = rom_rd_valid_o & rom_rd_ready_i`. On accept:
  - `out_pc_q <= pc_q`
  - `pc_q <= pc_q + 4` (mod 2^32; 32'hFFFF_FFFC wraps to 0)
  - `out_q <= 1`
- Response capture: `cap = out_q & rom_inst_valid_i`. The ROM returns data exactly the cycle after an accept.
  - On `cap`: `out_q` clears unless a new accept occurs in the same cycle.
  - If `drop_q` is 0, push `{out_pc_q, rom_inst_i}`.
  - If `drop_q` is 1, discard the data and clear `drop_q`.
  - If `out_q` is set and `rom_inst_valid_i` is 0, keep waiting. No timeout.
- Pop: `pop = id_valid_o & id_ready_i`.
- Issue rule: `rom_rd_valid_o = ~rst & ~redirect_i & (~out_q | rom_inst_valid_i) & (count + out_q − pop < FIFO_DEPTH)`.
  - This guarantees a captured response always has a FIFO slot.
  - Overflow is impossible by construction.
- `id_valid_o = (count != 0)`. `id_inst_o` and `id_pc_o` come straight from the FIFO head registers, with no input-to-output path.
- Redirect (`redirect_i = 1`):
  - `pc_q <= {redirect_pc_i[31:2], 2'b00}`.
  - The FIFO flushes to `count = 0`; a same-cycle pop and push are both ignored.
  - `drop_q <= out_q & ~cap`.
  - No request is issued in the redirect cycle.
- A redirect with a simultaneous capture discards that capture.
- Back-to-back redirects: the last one wins, and `drop_q` stays set until the single outstanding response returns.
- Reset values:
  - `rom_rd_valid_o = 0`
  - `rom_addr_o = RESET_PC >> 2`
  - `id_valid_o = 0`, `id_inst_o = 0`, `id_pc_o = 0`
  - `pc_q = RESET_PC`
  - `out_q = 0`, `drop_q = 0`, `count = 0`
- A mid-operation reset aborts any outstanding request. The response, if the ROM delivers one, is ignored because `out_q = 0`.

## Timing
- Cycle 0 after reset release: request `RESET_PC`.
- Cycle 1: capture. Cycle 2: `id_valid_o = 1`. First-fetch latency is 2 cycles.
- Steady state with `id_ready_i = 1`, ROM always ready and valid: one instruction per cycle with consecutive PCs and no bubbles.
- Redirect asserted in cycle R: request for the target in R+1, captured in R+2, `id_valid_o` with the target in R+3. `id_valid_o` is 0 from R+1 through R+2.
- Decode stall: at most `FIFO_DEPTH` entries are held and requests stop. On release, no instruction is lost or duplicated.

## Structure
- The shared defines file supplies `PORT_WORD_WIDTH`, `RegBus`, `ZeroWord`, `Enable`/`Disable` and `RESET_PC_DEFAULT`, alongside the existing core defines.
- Sub-module `fetch_fifo`: synchronous FIFO, 64-bit entries `{pc, inst}`, parameterised depth, with push, pop and flush, where flush has priority.
- PC, outstanding and drop tracking stay in `inst_fetch`.

## Test plan
- Reset release with ROM always ready and valid, `id_ready_i = 1` -> `rom_addr_o` = 0, 1, 2, ... per cycle; `id_pc_o` = 0x0, 0x4, 0x8 from cycle 2; `id_inst_o` equals the ROM contents.
- `id_ready_i = 0` for 5 cycles -> exactly 2 entries buffered, `rom_rd_valid_o = 0` while full; after release, PCs are contiguous with no duplicate.
- `redirect_i` with target 0x40 while a request is outstanding and the FIFO holds 1 entry -> the old response is dropped, the FIFO is empty, the next `id_pc_o` is 0x40 at R+3.
- `rom_inst_valid_i` held low 3 cycles after an accept -> no new request; capture on the first valid cycle; correct PC tag.
- `RESET_PC = 32'hFFFF_FFFC` -> the second fetch has `id_pc_o = 0x0`.
- `rst` pulsed with 1 outstanding and 2 buffered -> all outputs return to reset values; fetch restarts at `RESET_PC`.
